// File: rtl/rr_resource_arbiter_pkg.sv
// Shared definitions for the round-robin resource arbiter.
//   ARB_IDLE / ARB_GRANTED : FSM state encodings (1-bit, legacy-compatible)
//   ARB_MAX_NUM_REQ        : upper requester limit imposed by the encoder
//   arb_num_req_legal()    : parameter range check used at elaboration
package rr_resource_arbiter_pkg;

    localparam logic ARB_IDLE    = 1'b0;
    localparam logic ARB_GRANTED = 1'b1;

    localparam int unsigned ARB_MAX_NUM_REQ = 32;

    function automatic bit arb_num_req_legal(input int unsigned n);
        return (n >= 2) && (n <= ARB_MAX_NUM_REQ);
    endfunction

endpackage

// File: rtl/rr_resource_arbiter_ffo.sv
// find_first_one_index: priority encoder returning the index of the HIGHEST
// set bit of vector_i. Returns 0 for an all-zero vector, so callers must
// qualify the result with their own any-set check.
//   vector_i : VECTOR_LENGTH-bit input vector
//   index_o  : index of the highest set bit
module find_first_one_index #(
    parameter int unsigned VECTOR_LENGTH = 4,
    localparam int unsigned IDX_W = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1
) (
    input  logic [VECTOR_LENGTH-1:0] vector_i,
    output logic [IDX_W-1:0]         index_o
);

    // Ascending scan: the last matching bit (the highest) wins.
    always_comb begin
        index_o = '0;
        for (int unsigned i = 0; i < VECTOR_LENGTH; i++) begin
            if (vector_i[i]) begin
                index_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_resource_arbiter.sv
// rr_resource_arbiter: round-robin arbiter sharing one resource between
// NUM_REQ requesters. A registered one-hot grant is held until the owner
// pulses done, drops its request, or the hold timeout fires.
//   clk_in          : clock, rising edge
//   reset_in        : synchronous active-high reset
//   request_in      : level request per requester
//   done_in         : 1-cycle completion pulse from the owner
//   grant_out       : registered one-hot grant
//   grant_valid_out : a grant is held
//   grant_index_out : index of the current owner, 0 when idle
//   timeout_out     : 1-cycle pulse when a grant is revoked by timeout
module rr_resource_arbiter
    import rr_resource_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned MAX_HOLD_CYCLES = 64,
    parameter int unsigned HOLD_CNT_WIDTH  = 7
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic [NUM_REQ-1:0] request_in,
    input  logic [NUM_REQ-1:0] done_in,
    output logic [NUM_REQ-1:0] grant_out,
    output logic               grant_valid_out,
    output logic [31:0]        grant_index_out,
    output logic               timeout_out
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [HOLD_CNT_WIDTH-1:0] HOLD_LAST =
        HOLD_CNT_WIDTH'((MAX_HOLD_CYCLES == 0) ? 0 : MAX_HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] PTR_TOP = IDX_W'(NUM_REQ - 1);

    if (!arb_num_req_legal(NUM_REQ)) begin : g_bad_num_req
        $error("rr_resource_arbiter: NUM_REQ must be in 2..32");
    end

    logic                      state_q,   state_d;
    logic [NUM_REQ-1:0]        grant_q,   grant_d;
    logic [IDX_W-1:0]          index_q,   index_d;
    logic [IDX_W-1:0]          ptr_q,     ptr_d;
    logic [HOLD_CNT_WIDTH-1:0] hold_q,    hold_d;
    logic                      timeout_q, timeout_d;

    logic [NUM_REQ-1:0] ptr_mask;
    logic [NUM_REQ-1:0] masked_req;
    logic [IDX_W-1:0]   idx_masked;
    logic [IDX_W-1:0]   idx_all;
    logic [IDX_W-1:0]   winner;
    logic               owner_done;
    logic               owner_req;
    logic               timeout_hit;

    // Bits [ptr_q:0] form the first search window; highest-first scanning of
    // that window followed by the full vector yields descending order with wrap.
    always_comb begin
        ptr_mask = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            ptr_mask[i] = (i <= 32'(ptr_q));
        end
    end

    assign masked_req = request_in & ptr_mask;

    find_first_one_index #(.VECTOR_LENGTH(NUM_REQ)) u_ffo_masked (
        .vector_i (masked_req),
        .index_o  (idx_masked)
    );

    find_first_one_index #(.VECTOR_LENGTH(NUM_REQ)) u_ffo_all (
        .vector_i (request_in),
        .index_o  (idx_all)
    );

    assign winner = (|masked_req) ? idx_masked : idx_all;

    // The grant is one-hot, so ANDing with it selects the owner's bits.
    assign owner_done  = |(done_in & grant_q);
    assign owner_req   = |(request_in & grant_q);
    assign timeout_hit = (MAX_HOLD_CYCLES != 0) && (hold_q == HOLD_LAST);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        index_d   = index_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (|request_in) begin
                    grant_d = NUM_REQ'(1) << winner;
                    index_d = winner;
                    hold_d  = '0;
                    state_d = ARB_GRANTED;
                end
            end
            default: begin
                hold_d = (hold_q == '1) ? hold_q : hold_q + 1'b1;
                if (owner_done || !owner_req || timeout_hit) begin
                    grant_d   = '0;
                    index_d   = '0;
                    ptr_d     = (index_q == '0) ? PTR_TOP : index_q - 1'b1;
                    state_d   = ARB_IDLE;
                    // Only a revocation caused purely by the timeout is flagged.
                    timeout_d = timeout_hit && !owner_done && owner_req;
                end
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            index_q   <= '0;
            ptr_q     <= PTR_TOP;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            index_q   <= index_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant_out       = grant_q;
    assign grant_valid_out = |grant_q;
    assign grant_index_out = 32'(index_q);
    assign timeout_out     = timeout_q;

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Self-checking bench for rr_resource_arbiter: directed scenarios plus a
// randomized phase, all compared against a behavioural reference model.
module tb_rr_resource_arbiter;

    localparam int N    = 4;
    localparam int MAXH = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] done = '0;
    logic [N-1:0] grant_out;
    logic         grant_valid_out;
    logic [31:0]  grant_index_out;
    logic         timeout_out;

    rr_resource_arbiter #(
        .NUM_REQ         (N),
        .MAX_HOLD_CYCLES (MAXH),
        .HOLD_CNT_WIDTH  (4)
    ) dut (
        .clk_in          (clk),
        .reset_in        (rst),
        .request_in      (req),
        .done_in         (done),
        .grant_out       (grant_out),
        .grant_valid_out (grant_valid_out),
        .grant_index_out (grant_index_out),
        .timeout_out     (timeout_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: owner (-1 = none), priority pointer, visible grant cycles.
    int m_owner = -1;
    int m_ptr   = N - 1;
    int m_held  = 0;
    bit m_to    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walk downward from the pointer with wrap; the first requester found wins.
    function automatic int pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (ptr - k + N) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_update();
        bit d, r, tmo;
        if (rst) begin
            m_owner = -1; m_ptr = N - 1; m_held = 0; m_to = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            if (req != '0) begin
                m_owner = pick(req, m_ptr);
                m_held  = 1;
            end
        end else begin
            d   = done[m_owner];
            r   = req[m_owner];
            tmo = (MAXH != 0) && (m_held == MAXH);
            if (d || !r || tmo) begin
                m_to    = tmo && !d && r;
                m_ptr   = (m_owner == 0) ? N - 1 : m_owner - 1;
                m_owner = -1;
            end else begin
                m_to = 1'b0;
                m_held++;
            end
        end
    endtask

    task automatic step();
        logic [31:0] exp_grant;
        @(posedge clk);
        model_update();
        #1;
        exp_grant = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
        check("grant", 32'(grant_out), exp_grant);
        check("valid", 32'(grant_valid_out), (m_owner < 0) ? 32'd0 : 32'd1);
        check("index", grant_index_out, (m_owner < 0) ? 32'd0 : 32'(m_owner));
        check("timeout", 32'(timeout_out), 32'(m_to));
    endtask

    int exp_order[5] = '{3, 2, 1, 0, 3};
    int granted_cycles;
    int timeout_pulses;

    initial begin
        // 1: reset state, basic grant and release
        rst = 1'b1; step();
        check("t1_reset_grant", 32'(grant_out), 32'd0);
        check("t1_reset_timeout", 32'(timeout_out), 32'd0);
        rst = 1'b0; req = 4'b0101; step();
        check("t1_grant", 32'(grant_out), 32'b0100);
        check("t1_index", grant_index_out, 32'd2);
        done = 4'b0100; step();
        check("t1_released", 32'(grant_valid_out), 32'd0);
        done = '0; step();
        check("t1_next_grant", 32'(grant_out), 32'b0001);
        req = '0; step();

        // 2: all requesting, each owner done after 3 cycles
        req = 4'b1111; step();
        for (int k = 0; k < 5; k++) begin
            check("t2_order", grant_index_out, 32'(exp_order[k]));
            step(); step();
            done = grant_out; step();
            check("t2_idle_gap", 32'(grant_valid_out), 32'd0);
            done = '0; step();
        end
        req = '0; step();

        // 3: owner 1 never done -> revoked by timeout after MAXH cycles
        req = 4'b0010; step();
        granted_cycles = (grant_out == 4'b0010) ? 1 : 0;
        timeout_pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (grant_out == 4'b0010) granted_cycles++;
            if (timeout_out) begin
                timeout_pulses++;
                break;
            end
        end
        check("t3_granted_cycles", 32'(granted_cycles), 32'(MAXH));
        check("t3_timeout_pulses", 32'(timeout_pulses), 32'd1);
        req = 4'b1011; step();
        check("t3_ptr_at_0", grant_index_out, 32'd0);
        req = '0; step();

        // 4: owner drops its request, pending requester wins via wrap
        req = 4'b1000; step();
        req = '0; step();
        req = 4'b0100; step();
        check("t4_owner2", grant_index_out, 32'd2);
        req = 4'b1000; step();
        check("t4_released", 32'(grant_valid_out), 32'd0);
        check("t4_no_timeout", 32'(timeout_out), 32'd0);
        step();
        check("t4_wrap_winner", grant_index_out, 32'd3);
        done = 4'b1000; step();
        done = '0; req = '0; step();

        // 5: done coincides with timeout; non-owner done ignored
        req = 4'b0100; step();
        for (int i = 0; i < MAXH - 1; i++) step();
        done = 4'b0100; step();
        check("t5_released", 32'(grant_valid_out), 32'd0);
        check("t5_done_wins", 32'(timeout_out), 32'd0);
        done = '0; req = 4'b0001; step();
        check("t5_owner0", 32'(grant_out), 32'b0001);
        done = 4'b0100; step();
        check("t5_non_owner_done", 32'(grant_out), 32'b0001);
        done = '0;

        // 6: reset mid-grant
        rst = 1'b1; step();
        check("t6_reset_grant", 32'(grant_out), 32'd0);
        check("t6_reset_timeout", 32'(timeout_out), 32'd0);
        rst = 1'b0; req = 4'b1001; step();
        check("t6_first_after_reset", grant_index_out, 32'd3);
        req = '0; step();

        // Randomized phase
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
            done = ($urandom_range(0, 5) == 0) ? N'($urandom_range(0, 15)) : '0;
            rst  = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
